// File: rtl/ssp_frame_peer.sv
// ssp_frame_peer: far-end SSP frame peer on PCLK/CLEAR_B; host side SSPFSSIN/SSPRXD in, SSPFSSOUT/SSPTXD/SSPOE_B out; wr_* pushes TX buffer, rd_* pops RX buffer, rx_overrun flags dropped bytes; SSP_PEER_ECHO_EN echoes RX bytes into TX
module ssp_frame_peer #(
  parameter int   DEPTH    = 4,
  parameter logic IDLE_TXD = 1'b0
) (
  input  logic       PCLK,
  input  logic       CLEAR_B,
  input  logic       SSPFSSIN,
  input  logic       SSPRXD,
  output logic       SSPFSSOUT,
  output logic       SSPTXD,
  output logic       SSPOE_B,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic       rd_ready,
  output logic       rx_overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_SHIFT} tx_state_e;
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_e;
  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic fss_q, fss_d, txd_q, txd_d, oe_b_q, oe_b_d, ovr_q, ovr_d;
  logic [7:0] tx_mem_q [DEPTH], tx_mem_d [DEPTH], rx_mem_q [DEPTH], rx_mem_d [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic tx_full, tx_push, tx_pop, rx_full, rx_push, rx_pop, rx_done, echo;
  logic [7:0] rx_byte, tx_wdata;
  assign rx_done = rx_state_q == RX_RECV && rx_bit_q == 3'd0;
  assign rx_byte = {rx_sh_q[6:0], SSPRXD};
`ifdef SSP_PEER_ECHO_EN
  assign echo = rx_done;
`else
  assign echo = 1'b0;
`endif
  assign tx_full  = tx_cnt_q == FULL;
  assign wr_ready = !tx_full && !echo;
  assign tx_push  = (echo || wr_valid) && !tx_full;
  assign tx_wdata = echo ? rx_byte : wr_data;
  assign tx_pop   = tx_cnt_q != '0 && (tx_state_q == TX_IDLE || (tx_state_q == TX_SHIFT && tx_bit_q == 3'd0));
  assign rx_full  = rx_cnt_q == FULL;
  assign rd_valid = rx_cnt_q != '0;
  assign rd_data  = rx_mem_q[rx_rp_q];
  assign rx_pop   = rd_valid && rd_ready;
  assign rx_push  = rx_done && (!rx_full || rx_pop);
  assign ovr_d    = rx_done && rx_full && !rx_pop;
  assign SSPFSSOUT  = fss_q;
  assign SSPTXD     = txd_q;
  assign SSPOE_B    = oe_b_q;
  assign rx_overrun = ovr_q;
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push) tx_mem_d[tx_wp_q] = tx_wdata;
    if (rx_push) rx_mem_d[rx_wp_q] = rx_byte;
    tx_wp_d  = tx_push ? tx_wp_q + AW'(1) : tx_wp_q;
    tx_rp_d  = tx_pop ? tx_rp_q + AW'(1) : tx_rp_q;
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wp_d  = rx_push ? rx_wp_q + AW'(1) : rx_wp_q;
    rx_rp_d  = rx_pop ? rx_rp_q + AW'(1) : rx_rp_q;
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
  end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    fss_d      = fss_q;
    txd_d      = txd_q;
    oe_b_d     = oe_b_q;
    case (tx_state_q)
      TX_IDLE: if (tx_pop) begin
        tx_sh_d    = tx_mem_q[tx_rp_q];
        fss_d      = 1'b1;
        tx_state_d = TX_SYNC;
      end
      TX_SYNC: begin
        fss_d      = 1'b0;
        oe_b_d     = 1'b0;
        txd_d      = tx_sh_q[7];
        tx_sh_d    = {tx_sh_q[6:0], 1'b0};
        tx_bit_d   = 3'd7;
        tx_state_d = TX_SHIFT;
      end
      TX_SHIFT: if (tx_bit_q != 3'd0) begin
        txd_d    = tx_sh_q[7];
        tx_sh_d  = {tx_sh_q[6:0], 1'b0};
        tx_bit_d = tx_bit_q - 3'd1;
      end else begin
        txd_d      = IDLE_TXD;
        oe_b_d     = 1'b1;
        fss_d      = tx_pop;
        tx_sh_d    = tx_pop ? tx_mem_q[tx_rp_q] : tx_sh_q;
        tx_state_d = tx_pop ? TX_SYNC : TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end
  always_comb begin
    rx_state_d = rx_state_q;
    rx_sh_d    = rx_sh_q;
    rx_bit_d   = rx_bit_q;
    if (rx_state_q == RX_IDLE) begin
      rx_state_d = SSPFSSIN ? RX_RECV : RX_IDLE;
      rx_bit_d   = 3'd7;
    end else begin
      rx_sh_d    = rx_byte;
      rx_bit_d   = rx_bit_q - 3'd1;
      rx_state_d = rx_done ? RX_IDLE : RX_RECV;
    end
  end
  always_ff @(posedge PCLK or negedge CLEAR_B)
    if (!CLEAR_B) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      tx_bit_q   <= '0;
      rx_bit_q   <= '0;
      fss_q      <= 1'b0;
      txd_q      <= IDLE_TXD;
      oe_b_q     <= 1'b1;
      ovr_q      <= 1'b0;
      tx_mem_q   <= '{default: '0};
      rx_mem_q   <= '{default: '0};
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      tx_bit_q   <= tx_bit_d;
      rx_bit_q   <= rx_bit_d;
      fss_q      <= fss_d;
      txd_q      <= txd_d;
      oe_b_q     <= oe_b_d;
      ovr_q      <= ovr_d;
      tx_mem_q   <= tx_mem_d;
      rx_mem_q   <= rx_mem_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
    end
endmodule
